// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: turns load-use hazards, EX redirects, instruction-memory
// wait states and halt into PC-hold, redirect and IF/ID / ID/EX pipeline control.
module fetch_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        br_taken,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_target,
    input  logic        imem_ready,
    input  logic        halt_req,
    output logic        stop,
    output logic [31:0] ori_pc,
    output logic        jmp,
    output logic [2:0]  op,
    output logic [31:0] dest,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    // Extra flush cycles after the redirect cycle itself, minus one (counter runs down to zero).
    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_SLOTS > 1) ? 2'(FLUSH_SLOTS - 2) : 2'd0;

    logic [2:0]  state, state_nxt;
    logic [15:0] boot_cnt;
    logic [1:0]  flush_cnt, flush_cnt_nxt;
    logic [31:0] last_pc;
    logic        load_use;
    logic        boot_done;

    assign load_use  = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign boot_done = (32'(boot_cnt) + 32'd1) >= BOOT_CYCLES;
    assign ori_pc    = last_pc;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        stop          = 1'b0;
        jmp           = 1'b0;
        op            = '0;
        dest          = '0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        halted        = 1'b0;
        case (state)
            S_BOOT: begin
                stop       = 1'b1;
                ifid_flush = 1'b1;
                if (boot_done) state_nxt = S_RUN;
            end
            S_RUN, S_WAIT, S_FLUSH: begin
                if (halt_req) begin
                    stop       = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = S_HALT;
                end else if (br_taken) begin
                    jmp         = 1'b1;
                    op          = br_op;
                    dest        = br_target;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        state_nxt     = S_FLUSH;
                        flush_cnt_nxt = FLUSH_RELOAD;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else if (state == S_FLUSH) begin
                    ifid_flush = 1'b1;
                    if (flush_cnt == '0) state_nxt = S_RUN;
                    else flush_cnt_nxt = flush_cnt - 2'd1;
                end else if (load_use) begin
                    stop        = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    state_nxt   = S_RUN;
                end else if (!imem_ready) begin
                    stop       = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = S_WAIT;
                end else begin
                    // WAIT behaves as RUN once memory is ready, so stop drops in that same cycle.
                    state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                stop       = 1'b1;
                ifid_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                stop       = 1'b1;
                ifid_flush = 1'b1;
                state_nxt  = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            boot_cnt  <= '0;
            flush_cnt <= '0;
            last_pc   <= RESET_PC;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (state == S_BOOT && !boot_done) boot_cnt <= boot_cnt + 16'd1;
            if (!stop) last_pc <= fetch_pc;
        end
    end

endmodule
